div_result_stage: RTL and testbench
===================================

Name: div_result_stage

Overview:
- Registered output stage directly downstream of the combinational signed divider.
- Captures each divider result (quotient plus 4-bit status) under a valid/ready handshake.
- Buffers results in a 2-entry skid queue so that `o_ready` never depends combinationally on `i_ready`.
- Keeps sticky status flags and a saturating error counter for the control/display logic.

Parameters:
- K, 8, quotient width; must match the divider's K.
- CW, 8, width of the error counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream presents a result this cycle.
- i_div  input  K  quotient from the divider.
- i_status  input  4  divider status: [0] div-by-zero, [1] even parity nonzero, [2] all-ones, [3] out of range.
- o_ready  output  1  stage can accept a result this cycle.
- o_valid  output  1  head entry is valid.
- o_div  output  K  head entry quotient.
- o_status  output  4  head entry status.
- i_ready  input  1  downstream accepts the head entry this cycle.
- i_clr_sticky  input  1  clears o_sticky and o_err_cnt.
- o_sticky  output  4  OR of the status of every accepted input since the last clear or reset.
- o_err_cnt  output  CW  count of accepted inputs with status[0] or status[3] set; saturates at all-ones.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State becomes EMPTY.
  - o_valid=0, o_div=0, o_status=0, o_sticky=0, o_err_cnt=0; o_ready=1 from the next cycle.
  - Reset mid-operation flushes both entries with no drain.
  - Reset has priority over every other input.
- Handshakes:
  - Input transfer: i_valid && o_ready at the edge.
  - Output transfer: o_valid && i_ready at the edge.
  - Data is sampled only on a transfer. i_div and i_status are don't-care while i_valid=0.
- States: EMPTY (0 entries), ONE (1 entry), FULL (2 entries). o_ready = (state != FULL), driven from a register. o_valid = (state != EMPTY).
- Transitions:
  - EMPTY: input transfer -> ONE; the entry goes to the head.
  - ONE: input only -> FULL (entry goes to the skid slot). Output only -> EMPTY. Both -> stay ONE, head replaced by the new entry.
  - FULL: output transfer -> ONE, skid slot moves to the head. No input transfer is possible in FULL.
- Latency: an accepted result appears on o_div/o_status one cycle later when the stage was EMPTY. Order is strictly FIFO.
- Head outputs hold stable while o_valid=1 and i_ready=0.
- Sticky flags: on each input transfer, o_sticky |= i_status.
- Error counter: on each input transfer with (i_status[0] | i_status[3]), o_err_cnt increments unless it already equals 2^CW-1.
- i_clr_sticky:
  - Zeros o_sticky and o_err_cnt at the edge.
  - If an input transfer occurs in the same cycle, the result is o_sticky = i_status and o_err_cnt = 1 if the new input is an error, else 0 (new event wins over clear).
- Queue contents are unaffected by i_clr_sticky.

Optional Feature:
- Macro DIV_RESULT_DROP_ERR_EN.
- Defined: an input transfer with i_status[0] or i_status[3] set is not written into the queue (state unchanged), but still updates o_sticky and o_err_cnt. o_ready is unaffected.
- Undefined: every accepted input is queued, error results included.

Decomposition:
- Shared package div_pkg holds:
  - Status bit index constants: ST_DIVZERO=0, ST_PARITY=1, ST_ALLONES=2, ST_OVF=3.
  - Typedef `div_status_t` = logic [3:0].
  - State enum `rs_state_e` {RS_EMPTY, RS_ONE, RS_FULL}.
- One sub-module is natural: sat_counter (parameter CW; inputs inc, clr; clear-vs-increment priority as defined above).

Test Plan:
- Reset mid-FULL: load 0x05 and 0x07 with i_ready=0, then pulse i_rst -> next cycle o_valid=0, o_div=0, o_ready=1, o_sticky=0.
- Back-pressure: send 0x03, 0x04, 0x06 with i_ready=0 -> o_ready drops after two transfers and the third waits. Raise i_ready -> outputs 0x03, 0x04, 0x06 in order, one per cycle.
- Streaming: i_valid=1 and i_ready=1 continuously with quotients 1..10 -> o_div follows each input with one-cycle latency, no bubbles, state stays ONE.
- Sticky/count: inputs with status 4'b0001, 4'b1000, 4'b0100 -> o_sticky=4'b1101, o_err_cnt=2.
- Clear collision: i_clr_sticky=1 in the same cycle as an accepted status 4'b0001 -> o_sticky=4'b0001, o_err_cnt=1.
- Saturation with CW=2: five error inputs -> o_err_cnt=3. With DIV_RESULT_DROP_ERR_EN defined the queue stays EMPTY throughout.

Source files
------------

// File: rtl/div_result_stage_pkg.sv
// Shared types and constants for the divider result path.
// Status bit indices, the status vector type and the result-stage occupancy enum.
package div_pkg;

    localparam int ST_DIVZERO = 0;
    localparam int ST_PARITY  = 1;
    localparam int ST_ALLONES = 2;
    localparam int ST_OVF     = 3;

    typedef logic [3:0] div_status_t;

    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_ONE   = 2'd1,
        RS_FULL  = 2'd2
    } rs_state_e;

    // A result is an error when the divisor was zero or the quotient overflowed.
    function automatic logic is_err(input div_status_t st);
        return st[ST_DIVZERO] | st[ST_OVF];
    endfunction

endpackage

// File: rtl/div_result_stage_if.sv
// Upstream/downstream handshake bundle of the divider result stage.
// slave = the stage itself, master = whoever drives and consumes it.
interface div_result_stage_if
    import div_pkg::*;
#(
    parameter int K = 8
);
    logic           i_valid;
    logic [K-1:0]   i_div;
    div_status_t    i_status;
    logic           o_ready;
    logic           o_valid;
    logic [K-1:0]   o_div;
    div_status_t    o_status;
    logic           i_ready;

    modport slave (
        input  i_valid, i_div, i_status, i_ready,
        output o_ready, o_valid, o_div, o_status
    );

    modport master (
        output i_valid, i_div, i_status, i_ready,
        input  o_ready, o_valid, o_div, o_status
    );
endinterface

// File: rtl/div_result_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the counter at 1 (the new event survives).
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CW'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/div_result_stage.sv
// Registered 2-entry skid stage behind the signed divider, plus sticky status and error count.
// Build option: DIV_RESULT_DROP_ERR_EN discards error results instead of queueing them.
module div_result_stage
    import div_pkg::*;
#(
    parameter int K  = 8,
    parameter int CW = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    div_result_stage_if.slave   bus,
    input  logic                i_clr_sticky,
    output div_status_t         o_sticky,
    output logic [CW-1:0]       o_err_cnt
);
    localparam logic [1:0] S_EMPTY = 2'(RS_EMPTY);
    localparam logic [1:0] S_ONE   = 2'(RS_ONE);
    localparam logic [1:0] S_FULL  = 2'(RS_FULL);

    logic [1:0]   state, state_nx;
    logic         ready_q;
    logic [K-1:0] head_div, skid_div;
    div_status_t  head_st, skid_st;
    logic         in_xfer, out_xfer, drop, wr_en;
    logic         head_from_in, head_from_skid, skid_load;

    assign in_xfer  = bus.i_valid && ready_q;
    assign out_xfer = (state != S_EMPTY) && bus.i_ready;

`ifdef DIV_RESULT_DROP_ERR_EN
    assign drop = is_err(bus.i_status);
`else
    assign drop = 1'b0;
`endif

    assign wr_en = in_xfer && !drop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        head_from_in   = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (wr_en) begin
                    state_nx     = S_ONE;
                    head_from_in = 1'b1;
                end
            end
            S_ONE: begin
                if (wr_en && out_xfer) begin
                    head_from_in = 1'b1;
                end else if (wr_en) begin
                    state_nx  = S_FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_nx = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_xfer) begin
                    state_nx       = S_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    // ready is registered from the next state so it never sees i_ready combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_EMPTY;
            ready_q  <= 1'b1;
            head_div <= '0;
            head_st  <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != S_FULL);
            if (head_from_in) begin
                head_div <= bus.i_div;
                head_st  <= bus.i_status;
            end else if (head_from_skid) begin
                head_div <= skid_div;
                head_st  <= skid_st;
            end
        end
    end

    // NOTE: the skid slot is pure storage guarded by state, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (skid_load) begin
            skid_div <= bus.i_div;
            skid_st  <= bus.i_status;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sticky <= '0;
        end else if (in_xfer) begin
            o_sticky <= (i_clr_sticky ? '0 : o_sticky) | bus.i_status;
        end else if (i_clr_sticky) begin
            o_sticky <= '0;
        end
    end

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .inc (in_xfer && is_err(bus.i_status)),
        .clr (i_clr_sticky),
        .cnt (o_err_cnt)
    );

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = (state != S_EMPTY);
    assign bus.o_div    = head_div;
    assign bus.o_status = head_st;

endmodule

// File: tb/tb_div_result_stage.sv
// Self-checking bench for div_result_stage: directed scenarios plus a randomized run
// against a queue-based reference model. Honours DIV_RESULT_DROP_ERR_EN if defined.
module tb_div_result_stage;
    localparam int K  = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [K-1:0] d;
        logic [3:0]   s;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [3:0]    sticky;
    logic [CW-1:0] err_cnt;

    div_result_stage_if #(.K(K)) bus ();

    div_result_stage #(.K(K), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .i_clr_sticky (clr),
        .o_sticky     (sticky),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a FIFO of at most two results plus the sticky/count bookkeeping.
    ent_t          mq[$];
    logic [3:0]    m_sticky = '0;
    int            m_cnt    = 0;
    localparam int CNT_MAX  = (1 << CW) - 1;

    function automatic bit model_err(input logic [3:0] s);
        return s[0] | s[3];
    endfunction

    function automatic bit model_drops(input logic [3:0] s);
`ifdef DIV_RESULT_DROP_ERR_EN
        return model_err(s);
`else
        return (s == 4'hF) && 1'b0;
`endif
    endfunction

    task automatic cycle(input bit r, input bit v, input logic [K-1:0] d,
                         input logic [3:0] s, input bit rdy, input bit c);
        bit in_x, out_x;
        rst          = r;
        bus.i_valid  = v;
        bus.i_div    = d;
        bus.i_status = s;
        bus.i_ready  = rdy;
        clr          = c;
        in_x  = v && (mq.size() < 2);
        out_x = (mq.size() > 0) && rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_sticky = '0;
            m_cnt    = 0;
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x && !model_drops(s)) mq.push_back('{d: d, s: s});
            if (in_x) begin
                m_sticky = (c ? 4'h0 : m_sticky) | s;
                m_cnt    = (c ? 0 : m_cnt) + (model_err(s) ? 1 : 0);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            end else if (c) begin
                m_sticky = '0;
                m_cnt    = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 1, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, '0, 0, 0);
        cycle(1, 0, '0, '0, 0, 0);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.o_ready); end
        n_tests++; if (bus.o_div !== 8'h00) begin n_fail++; $display("FAIL reset_div got %h exp 00", bus.o_div); end
        n_tests++; if (bus.o_status !== 4'h0) begin n_fail++; $display("FAIL reset_status got %b exp 0000", bus.o_status); end
        n_tests++; if (sticky !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got %b exp 0000", sticky); end
        n_tests++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_errcnt got %0d exp 0", err_cnt); end
    endtask

    task automatic test_reset_mid_full();
        cycle(0, 1, 8'h05, 4'b0100, 0, 0);
        cycle(0, 1, 8'h07, 4'b0000, 0, 0);
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", bus.o_ready); end
        n_tests++; if (bus.o_div !== 8'h05) begin n_fail++; $display("FAIL full_head got %h exp 05", bus.o_div); end
        n_tests++; if (sticky !== 4'b0100) begin n_fail++; $display("FAIL full_sticky got %b exp 0100", sticky); end
        cycle(1, 0, '0, '0, 0, 0);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", bus.o_valid); end
        n_tests++; if (bus.o_div !== 8'h00) begin n_fail++; $display("FAIL midrst_div got %h exp 00", bus.o_div); end
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", bus.o_ready); end
        n_tests++; if (sticky !== 4'h0) begin n_fail++; $display("FAIL midrst_sticky got %b exp 0000", sticky); end
    endtask

    task automatic test_back_pressure();
        cycle(0, 1, 8'h03, '0, 0, 0);
        n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", bus.o_ready); end
        cycle(0, 1, 8'h04, '0, 0, 0);
        n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got %b exp 0", bus.o_ready); end
        cycle(0, 1, 8'h06, '0, 0, 0);
        n_tests++; if (bus.o_div !== 8'h03 || bus.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold got div %h ready %b exp 03/0", bus.o_div, bus.o_ready); end
        cycle(0, 1, 8'h06, '0, 1, 0);
        n_tests++; if (bus.o_div !== 8'h04 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out2 got div %h valid %b exp 04/1", bus.o_div, bus.o_valid); end
        cycle(0, 1, 8'h06, '0, 1, 0);
        n_tests++; if (bus.o_div !== 8'h06 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out3 got div %h valid %b exp 06/1", bus.o_div, bus.o_valid); end
        cycle(0, 0, '0, '0, 1, 0);
        n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", bus.o_valid); end
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 10; k++) begin
            cycle(0, 1, K'(k), '0, 1, 0);
            n_tests++; if (bus.o_div !== K'(k) || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_%0d got div %h valid %b ready %b exp %h/1/1",
                                   k, bus.o_div, bus.o_valid, bus.o_ready, K'(k)); end
        end
        idle(1);
    endtask

    task automatic test_sticky_count();
        cycle(0, 0, '0, '0, 1, 1);
        cycle(0, 1, 8'h11, 4'b0001, 1, 0);
        cycle(0, 1, 8'h22, 4'b1000, 1, 0);
        cycle(0, 1, 8'h33, 4'b0100, 1, 0);
        idle(1);
        n_tests++; if (sticky !== 4'b1101) begin n_fail++; $display("FAIL sticky_or got %b exp 1101", sticky); end
        n_tests++; if (err_cnt !== CW'(2)) begin n_fail++; $display("FAIL errcnt_two got %0d exp 2", err_cnt); end
    endtask

    task automatic test_clear_collision();
        cycle(0, 1, 8'h44, 4'b0001, 1, 1);
        n_tests++; if (sticky !== 4'b0001) begin n_fail++; $display("FAIL clrcol_sticky got %b exp 0001", sticky); end
        n_tests++; if (err_cnt !== CW'(1)) begin n_fail++; $display("FAIL clrcol_cnt got %0d exp 1", err_cnt); end
        cycle(0, 0, '0, '0, 1, 1);
        n_tests++; if (sticky !== 4'h0 || err_cnt !== '0) begin
            n_fail++; $display("FAIL clr_only got sticky %b cnt %0d exp 0000/0", sticky, err_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, K'($urandom), 4'b0001, 1, 0);
`ifdef DIV_RESULT_DROP_ERR_EN
            n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL drop_empty_%0d got %b exp 0", i, bus.o_valid); end
`endif
        end
        n_tests++; if (err_cnt !== CW'(3)) begin n_fail++; $display("FAIL sat_cnt got %0d exp 3", err_cnt); end
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(0, ($urandom_range(0, 3) != 0), K'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            n_tests++;
            if (bus.o_valid !== (mq.size() > 0) || bus.o_ready !== (mq.size() < 2) ||
                sticky !== m_sticky || err_cnt !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_ctl_%0d got v%b r%b st%b c%0d exp v%b r%b st%b c%0d", i,
                         bus.o_valid, bus.o_ready, sticky, err_cnt,
                         (mq.size() > 0), (mq.size() < 2), m_sticky, m_cnt);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if (bus.o_div !== mq[0].d || bus.o_status !== mq[0].s) begin
                    n_fail++;
                    $display("FAIL rand_head_%0d got %h/%b exp %h/%b", i,
                             bus.o_div, bus.o_status, mq[0].d, mq[0].s);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        bus.i_valid = 1'b0; bus.i_div = '0; bus.i_status = '0; bus.i_ready = 1'b0;
        #1;
        test_reset();
        test_reset_mid_full();
        test_back_pressure();
        test_streaming();
        test_sticky_count();
        test_clear_collision();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
